// File: rtl/pipe_addsub_acc.sv
// Pipelined add/sub/accumulate/load unit with a start/in_ready input handshake,
// a valid/out_ready output handshake, an optional saturation mode and an overflow flag.
module pipe_addsub_acc #(
  parameter int W   = 12,
  parameter int LAT = 1,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         valid,
  input  logic         out_ready
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [LAT-1:0] stg_valid;
  logic [LAT-1:0] stg_ovf;
  logic [W-1:0]   stg_y [LAT];
  logic [W-1:0]   acc_q;

  logic         stall;
  logic         accept;
  logic [W:0]   r;
  logic         ovf_next;
  logic [W-1:0] y_next;

  assign stall    = stg_valid[LAT-1] && !out_ready;
  assign in_ready = !stall;
  assign accept   = start && in_ready;

  // Compute in W+1 bits so the top bit is the carry (ADD/ACC) or borrow (SUB).
  always_comb begin
    r        = '0;
    ovf_next = 1'b0;
    case (op)
      OP_ADD: begin
        r        = {1'b0, a} + {1'b0, b};
        ovf_next = r[W];
      end
      OP_SUB: begin
        r        = {1'b0, a} - {1'b0, b};
        ovf_next = r[W];
      end
      OP_ACC: begin
        r        = {1'b0, acc_q} + {1'b0, a};
        ovf_next = r[W];
      end
      default: begin
        r        = {1'b0, a};
        ovf_next = 1'b0;
      end
    endcase
    y_next = r[W-1:0];
    if (SAT != 0 && ovf_next) begin
      y_next = (op == OP_SUB) ? '0 : '1;
    end
  end

  // The whole pipe freezes while the head result waits for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      stg_ovf   <= '0;
      acc_q     <= '0;
      for (int i = 0; i < LAT; i++) begin
        stg_y[i] <= '0;
      end
    end else if (!stall) begin
      stg_valid[0] <= accept;
      if (accept) begin
        stg_y[0]   <= y_next;
        stg_ovf[0] <= ovf_next;
      end
      for (int i = 1; i < LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        if (stg_valid[i-1]) begin
          stg_y[i]   <= stg_y[i-1];
          stg_ovf[i] <= stg_ovf[i-1];
        end
      end
      if (accept && (op == OP_ACC || op == OP_LOAD)) begin
        acc_q <= y_next;
      end
    end
  end

  assign y     = stg_y[LAT-1];
  assign ovf   = stg_ovf[LAT-1];
  assign valid = stg_valid[LAT-1];

endmodule
